// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and in-order load responses onto a
// single register-file write port, tracking outstanding load destinations in
// a FIFO tag queue that also drives the decode-stage RAW/WAW hazard check.
module wb_arbiter #(
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_rd,
    output logic        ld_issue_ready,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    input  logic [4:0]  chk_rd,
    output logic        hazard,
    output logic [4:0]  a_rd,
    output logic [31:0] d_rd,
    output logic        we_rd
);

    localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [4:0]       tags [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             push;
    logic             pop;
    logic [4:0]       head_tag;
    logic             sel_valid;
    logic [4:0]       sel_rd;
    logic [31:0]      sel_data;

    // Queue handshakes; the ALU is never stalled, so loads only drain when it is idle
    always_comb begin
        ld_issue_ready = (count != CNT_W'(TAG_DEPTH));
        ld_ready       = !alu_valid && (count != CNT_W'(0));
        push           = ld_issue && ld_issue_ready;
        pop            = ld_valid && ld_ready;
        head_tag       = tags[rd_ptr];
    end

    // Hazard against every occupied queue slot; x0 destinations never stall
    always_comb begin
        logic [PTR_W-1:0] offset;
        hazard = 1'b0;
        offset = '0;
        for (int i = 0; i < TAG_DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr;
            if ((CNT_W'(offset) < count) && (tags[i] != 5'd0) &&
                ((tags[i] == chk_rs1) || (tags[i] == chk_rs2) || (tags[i] == chk_rd))) begin
                hazard = 1'b1;
            end
        end
    end

    // Tag storage; occupancy is tracked by the pointers, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            tags[wr_ptr] <= ld_issue_rd;
        end
    end

    // Queue pointers and occupancy count
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Write-source selection with fixed ALU priority
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = 5'd0;
        sel_data  = 32'd0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end else if (pop) begin
            sel_valid = 1'b1;
            sel_rd    = head_tag;
            sel_data  = ld_data;
        end
    end

    // Registered write port; address/data hold when nothing is selected
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            a_rd  <= 5'd0;
            d_rd  <= 32'd0;
            we_rd <= 1'b0;
        end else begin
            we_rd <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid) begin
                a_rd <= sel_rd;
                d_rd <= sel_data;
            end
        end
    end

endmodule
